rcl_result_tally: RTL and testbench

//  Downstream consumer of the circle/line relation stage. Takes its 2-bit result

---
 rtl/rcl_result_tally.sv | 131 +++++++++++++
 tb/tb_rcl_result_tally.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rcl_result_tally.sv
// Result-class tally: counts circle/line relation codes over fixed frames and
// streams each frame's four tallies as a 4-beat valid/ready report.

// One class tally. Clears on frame end; exposes the count including this
// cycle's increment so the frame snapshot sees the final result.
module rcl_tally_lane #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] nxt
);
  logic [CNT_W-1:0] cnt;

  assign nxt = cnt + CNT_W'(inc);

  // Live tally: restart at zero after a frame end, otherwise count hits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= nxt;
  end
endmodule

module rcl_result_tally #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       in_class,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_data,
  output logic [1:0]       out_beat,
  output logic             out_last,
  output logic             busy,
  output logic             overflow
);
  localparam int NUM_LANES = 4;
  localparam int FC_W      = $clog2(FRAME_LEN);

  typedef enum logic {IDLE, REPORT} state_t;

  state_t                             state, state_n;
  logic [1:0]                         beat, beat_n;
  logic [FC_W-1:0]                    frame_cnt;
  logic [NUM_LANES-1:0][CNT_W-1:0]    live_nxt;
  logic [NUM_LANES-1:0][CNT_W-1:0]    snap;
  logic                               frame_end, accept, load, ovf_set;

  assign frame_end = in_valid && (frame_cnt == FC_W'(FRAME_LEN - 1));
  assign accept    = (state == REPORT) && out_ready;

  // Position within the current frame; wraps on frame end with no gap cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            frame_cnt <= '0;
    else if (frame_end) frame_cnt <= '0;
    else if (in_valid)  frame_cnt <= frame_cnt + 1'b1;
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      rcl_tally_lane #(.CNT_W(CNT_W)) u_lane (
        .clk (clk),
        .rst (rst),
        .inc (in_valid && (in_class == 2'(g))),
        .clr (frame_end),
        .nxt (live_nxt[g])
      );
    end
  endgenerate

  // Report FSM next-state: a frame end only loads a new snapshot when the
  // report path is free, i.e. idle or retiring its last beat this cycle
  always_comb begin
    state_n = state;
    beat_n  = beat;
    load    = 1'b0;
    ovf_set = 1'b0;
    case (state)
      IDLE: begin
        if (frame_end) begin
          state_n = REPORT;
          beat_n  = 2'd0;
          load    = 1'b1;
        end
      end
      REPORT: begin
        if (accept) begin
          beat_n = beat + 2'd1;
          if (beat == 2'd3) begin
            if (frame_end) begin
              load   = 1'b1;
              beat_n = 2'd0;
            end else begin
              state_n = IDLE;
            end
          end
        end
        if (frame_end && !(accept && beat == 2'd3)) ovf_set = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state, beat index, snapshot and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= 2'd0;
      snap     <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
      if (load)    snap     <= live_nxt;
      if (ovf_set) overflow <= 1'b1;
    end
  end

  assign out_valid = (state == REPORT);
  assign busy      = (state == REPORT);
  assign out_beat  = beat;
  assign out_last  = out_valid && (beat == 2'd3);
  assign out_data  = out_valid ? snap[beat] : '0;
endmodule

// File: tb/tb_rcl_result_tally.sv
// Scoreboard bench: stimulus pushes expected report beats, a negedge monitor
// pops and compares each accepted beat; directed checks cover timing/flags.
module tb_rcl_result_tally;
  typedef struct {
    int data;
    int beat;
    int last;
  } exp_t;

  logic       clk, rst;
  logic       in_valid, out_ready, out_valid, out_last, busy, overflow;
  logic [1:0] in_class, out_beat;
  logic [2:0] out_data;

  logic       in_valid2, out_ready2, out_valid2, out_last2, busy2, overflow2;
  logic [1:0] in_class2, out_beat2;
  logic [4:0] out_data2;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  rcl_result_tally #(.FRAME_LEN(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_class(in_class),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beat(out_beat), .out_last(out_last), .busy(busy), .overflow(overflow)
  );

  rcl_result_tally #(.FRAME_LEN(16), .CNT_W(5)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_class(in_class2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_beat(out_beat2), .out_last(out_last2), .busy(busy2), .overflow(overflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int d0, input int d1, input int d2, input int d3);
    q.push_back('{d0, 0, 0});
    q.push_back('{d1, 1, 0});
    q.push_back('{d2, 2, 0});
    q.push_back('{d3, 3, 1});
  endtask

  // Drive one result per cycle; inputs change 1 time unit after the edge
  task automatic send4(input int c0, input int c1, input int c2, input int c3);
    int c[4];
    c = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_class = 2'(c[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d beats outstanding, expected 0", name, q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every accepted beat must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected beat: beat %0d data %0d, expected none", out_beat, out_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("beat_idx",  int'(out_beat), e.beat);
        chk("beat_data", int'(out_data), e.data);
        chk("beat_last", int'(out_last), e.last);
      end
    end
  end

  initial begin
    int bcnt;
    rst = 1'b1; in_valid = 1'b0; in_class = 2'd0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_class2 = 2'd0; out_ready2 = 1'b0;
    @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_ovf",   int'(overflow), 0);
    chk("rst_data",  int'(out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: simple frame, always ready
    out_ready = 1'b1;
    push(1, 1, 2, 0);
    in_valid = 1'b1; in_class = 2'd0; @(posedge clk); #1;
    in_class = 2'd1; @(posedge clk); #1;
    in_class = 2'd2; @(posedge clk); #1;
    in_class = 2'd2;
    chk("t1_valid_before", int'(out_valid), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t1_valid_lat1", int'(out_valid), 1);
    bcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("t1_busy_cycles", bcnt, 4);
    drain("t1");

    // 2: stalled report holds beat 0
    out_ready = 1'b0;
    send4(0, 1, 2, 2);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", int'(out_valid), 1);
      chk("t2_hold_beat",  int'(out_beat), 0);
      chk("t2_hold_data",  int'(out_data), 1);
      @(posedge clk); #1;
    end
    push(1, 1, 2, 0);
    out_ready = 1'b1;
    drain("t2");
    chk("t2_ovf", int'(overflow), 0);

    // 4: second frame ends on the beat-3 accept
    push(2, 1, 1, 0);
    push(1, 0, 2, 1);
    send4(0, 0, 1, 2);
    in_valid = 1'b1;
    begin
      int c[4];
      c = '{3, 2, 2, 0};
      for (int i = 0; i < 4; i++) begin
        in_class = 2'(c[i]);
        chk("t4_no_bubble", int'(out_valid), 1);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    chk("t4_valid_after", int'(out_valid), 1);
    chk("t4_beat_restart", int'(out_beat), 0);
    chk("t4_ovf", int'(overflow), 0);
    drain("t4");
    chk("t4_ovf_end", int'(overflow), 0);

    // 5a: all illegal codes
    push(0, 0, 0, 4);
    send4(3, 3, 3, 3);
    drain("t5");

    // 3: second frame completes while first report stalls
    out_ready = 1'b0;
    send4(1, 1, 1, 0);
    send4(2, 2, 2, 2);
    chk("t3_ovf", int'(overflow), 1);
    chk("t3_beat", int'(out_beat), 0);
    chk("t3_data", int'(out_data), 1);
    push(1, 3, 0, 0);
    out_ready = 1'b1;
    drain("t3");
    repeat (3) @(posedge clk); #1;
    chk("t3_single_report", int'(out_valid), 0);
    chk("t3_ovf_sticky", int'(overflow), 1);

    // 6: reset mid-report, then a fresh frame
    q.push_back('{1, 0, 0});
    send4(1, 3, 1, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t6_beat1", int'(out_beat), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_data",  int'(out_data), 0);
    chk("t6_rst_beat",  int'(out_beat), 0);
    chk("t6_rst_last",  int'(out_last), 0);
    chk("t6_rst_busy",  int'(busy), 0);
    chk("t6_rst_ovf",   int'(overflow), 0);
    chk("t6_q_empty",   q.size(), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(0, 1, 2, 1);
    send4(2, 2, 3, 1);
    drain("t6");

    // 5b: FRAME_LEN=16, every result class 10
    out_ready2 = 1'b1;
    in_valid2 = 1'b1; in_class2 = 2'd2;
    repeat (16) begin @(posedge clk); #1; end
    in_valid2 = 1'b0;
    chk("t5b_valid", int'(out_valid2), 1);
    for (int b = 0; b < 4; b++) begin
      chk("t5b_beat", int'(out_beat2), b);
      chk("t5b_data", int'(out_data2), (b == 2) ? 16 : 0);
      chk("t5b_last", int'(out_last2), (b == 3) ? 1 : 0);
      @(posedge clk); #1;
    end
    chk("t5b_idle", int'(out_valid2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
